five_sons_input_ctrl: RTL and testbench



---
 rtl/five_sons_input_ctrl_if.sv | 25 ++
 rtl/five_sons_input_ctrl.sv | 177 +++++++++++++++++
 tb/tb_five_sons_input_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/five_sons_input_ctrl_if.sv
// Signal bundle between the push-button front end and the game datapath.
// master drives the keys and game_over; slave is the input controller.
interface five_sons_input_ctrl_if;
  logic key_put;
  logic key_right;
  logic key_down;
  logic game_over;
  logic put;
  logic right;
  logic down;
  logic turn_control;
  logic change_able_read;
  logic control_set;
  logic busy;

  modport master (
    output key_put, key_right, key_down, game_over,
    input  put, right, down, turn_control, change_able_read, control_set, busy
  );

  modport slave (
    input  key_put, key_right, key_down, game_over,
    output put, right, down, turn_control, change_able_read, control_set, busy
  );
endinterface

// File: rtl/five_sons_input_ctrl.sv
// Key synchronise/debounce plus the placement sequencer that drives the datapath strobes.
// Strobes are registered decodes of the FSM state, so they are glitch-free and clear at once on reset.
module five_sons_input_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int PULSE_LEN = 4
) (
  input logic                   clock,
  input logic                   resetn,
  five_sons_input_ctrl_if.slave bus
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int PW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [3:0] {
    S_HOME,
    S_PLAY,
    S_CHOICE,
    S_PUT,
    S_GAP,
    S_TURN,
    S_MOVE_R,
    S_MOVE_D,
    S_OVER
  } state_t;

  // Key index 0 = put, 1 = right, 2 = down.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] key_event;

  assign raw = {bus.key_down, bus.key_right, bus.key_put};

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           accepted;
    logic           ev;

    // A run of DB_CYCLES samples disagreeing with the accepted level flips it;
    // only a flip to 1 is reported, so a held key fires exactly once.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cnt      <= '0;
        accepted <= 1'b0;
        ev       <= 1'b0;
      end else begin
        ev <= 1'b0;
        if (sync2[k] == accepted) begin
          cnt <= '0;
        end else if (cnt == DBW'(DB_CYCLES - 1)) begin
          cnt      <= '0;
          accepted <= sync2[k];
          ev       <= sync2[k];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_event[k] = ev;
  end

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          last;
  logic          put_d, right_d, down_d, turn_d, car_d, cs_d, busy_d;

  assign last = (cnt_q == PW'(PULSE_LEN - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_HOME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    put_d   = 1'b0;
    right_d = 1'b0;
    down_d  = 1'b0;
    turn_d  = 1'b0;
    car_d   = 1'b0;
    cs_d    = 1'b0;
    busy_d  = 1'b1;

    case (state_q)
      S_HOME: begin
        cs_d = 1'b1;
        if (last) state_d = S_PLAY;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_PLAY: begin
        busy_d = 1'b0;
        // A win outranks any key seen in the same cycle.
        if (bus.game_over)     state_d = S_OVER;
        else if (key_event[0]) state_d = S_CHOICE;
        else if (key_event[1]) state_d = S_MOVE_R;
        else if (key_event[2]) state_d = S_MOVE_D;
      end
      S_CHOICE: begin
        car_d   = 1'b1;
        state_d = S_PUT;
      end
      S_PUT: begin
        put_d = 1'b1;
        if (last) state_d = S_GAP;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_GAP: begin
        if (last) state_d = S_TURN;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_TURN: begin
        turn_d = 1'b1;
        if (last) state_d = S_HOME;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_MOVE_R: begin
        right_d = 1'b1;
        if (last) state_d = S_PLAY;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_MOVE_D: begin
        down_d = 1'b1;
        if (last) state_d = S_PLAY;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S_OVER: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = S_HOME;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.put              <= 1'b0;
      bus.right            <= 1'b0;
      bus.down             <= 1'b0;
      bus.turn_control     <= 1'b0;
      bus.change_able_read <= 1'b0;
      bus.control_set      <= 1'b0;
      bus.busy             <= 1'b0;
    end else begin
      bus.put              <= put_d;
      bus.right            <= right_d;
      bus.down             <= down_d;
      bus.turn_control     <= turn_d;
      bus.change_able_read <= car_d;
      bus.control_set      <= cs_d;
      bus.busy             <= busy_d;
    end
  end

endmodule

// File: tb/tb_five_sons_input_ctrl.sv
// Bench for five_sons_input_ctrl: directed scenarios with literal expectations plus
// randomized keys, all compared every cycle against a queue-based behavioural model.
module tb_five_sons_input_ctrl;

  localparam int DB = 4;
  localparam int P  = 2;

  // Output word layout: {busy, control_set, change_able_read, turn_control, down, right, put}
  localparam logic [6:0] W_IDLE = 7'b0000000;
  localparam logic [6:0] W_PUT  = 7'b1000001;
  localparam logic [6:0] W_R    = 7'b1000010;
  localparam logic [6:0] W_D    = 7'b1000100;
  localparam logic [6:0] W_TURN = 7'b1001000;
  localparam logic [6:0] W_CAR  = 7'b1010000;
  localparam logic [6:0] W_CS   = 7'b1100000;
  localparam logic [6:0] W_GAP  = 7'b1000000;

  logic clock;
  logic resetn;
  five_sons_input_ctrl_if bus ();

  five_sons_input_ctrl #(.DB_CYCLES(DB), .PULSE_LEN(P)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [6:0] dut_word;
  assign dut_word = {bus.busy, bus.control_set, bus.change_able_read,
                     bus.turn_control, bus.down, bus.right, bus.put};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: a key's level flips once the last DB synchronised samples all disagree
  // with it. Sequencer: each accepted action enqueues the list of output words it
  // must produce; PLAY is "queue empty", OVER is absorbing.
  logic [6:0]  plan [$];
  logic [6:0]  cur;
  logic [6:0]  exp_word = W_IDLE;
  bit          m_play;
  bit          m_over;
  logic [15:0] hist [3];
  logic [2:0]  acc;
  logic [2:0]  ev;
  logic [2:0]  m_raw;
  bit          all_diff;

  function automatic void push_n(input logic [6:0] w, input int n);
    for (int i = 0; i < n; i++) plan.push_back(w);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plan.delete();
      push_n(W_CS, P);
      cur      = plan.pop_front();
      exp_word = W_IDLE;
      m_play   = 1'b0;
      m_over   = 1'b0;
      acc      = '0;
      ev       = '0;
      for (int k = 0; k < 3; k++) hist[k] = '0;
    end else begin
      exp_word = cur;
      if (m_over) begin
        cur = W_IDLE;
      end else if (m_play) begin
        if (bus.game_over) begin
          m_play = 1'b0;
          m_over = 1'b1;
        end else if (ev[0]) begin
          push_n(W_CAR, 1);
          push_n(W_PUT, P);
          push_n(W_GAP, P);
          push_n(W_TURN, P);
          push_n(W_CS, P);
        end else if (ev[1]) begin
          push_n(W_R, P);
        end else if (ev[2]) begin
          push_n(W_D, P);
        end
        if (plan.size() > 0) begin
          cur    = plan.pop_front();
          m_play = 1'b0;
        end
      end else if (plan.size() > 0) begin
        cur = plan.pop_front();
      end else begin
        cur    = W_IDLE;
        m_play = 1'b1;
      end

      m_raw = {bus.key_down, bus.key_right, bus.key_put};
      for (int k = 0; k < 3; k++) begin
        hist[k]  = {hist[k][14:0], m_raw[k]};
        ev[k]    = 1'b0;
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[k][j] == acc[k]) all_diff = 1'b0;
        if (all_diff) begin
          acc[k] = ~acc[k];
          ev[k]  = acc[k];
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clock) begin
    if (cmp_en) check("cycle_word", int'(dut_word), int'(exp_word));
  end

  // ---------------- stimulus helpers ----------------
  int cyc, n_put, n_right, n_down, n_turn, n_car, n_cs, first_car, first_turn, first_cs;

  task automatic clear_counts();
    cyc = 0; n_put = 0; n_right = 0; n_down = 0; n_turn = 0; n_car = 0; n_cs = 0;
    first_car = -1; first_turn = -1; first_cs = -1;
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    if (bus.put)          n_put++;
    if (bus.right)        n_right++;
    if (bus.down)         n_down++;
    if (bus.turn_control) n_turn++;
    if (bus.change_able_read) begin
      n_car++;
      if (first_car < 0) first_car = cyc;
    end
    if (bus.turn_control && first_turn < 0) first_turn = cyc;
    if (bus.control_set) begin
      n_cs++;
      if (first_cs < 0) first_cs = cyc;
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    bus.game_over = 1'b0;
    resetn = 1'b1;
  endtask

  bit seen;

  initial begin
    resetn        = 1'b1;
    bus.key_put   = 1'b0;
    bus.key_right = 1'b0;
    bus.key_down  = 1'b0;
    bus.game_over = 1'b0;
    #3 resetn = 1'b0;
    step();
    step();
    cmp_en = 1'b1;

    // T1: reset, then the HOME pulse
    check("t1_reset_word", int'(dut_word), 0);
    resetn = 1'b1;
    step();
    check("t1_cs_c1", int'(bus.control_set), 1);
    step();
    check("t1_cs_c2", int'(bus.control_set), 1);
    step();
    check("t1_word_c3", int'(dut_word), 0);
    step();

    // T2: held put key -> one full placement sequence
    clear_counts();
    bus.key_put = 1'b1;
    repeat (20) step();
    bus.key_put = 1'b0;
    repeat (10) step();
    check("t2_first_car", first_car, 8);
    check("t2_first_turn", first_turn, 13);
    check("t2_n_car", n_car, 1);
    check("t2_n_put", n_put, 2);
    check("t2_n_turn", n_turn, 2);
    check("t2_n_cs", n_cs, 2);

    // T3: glitch then clean right press
    clear_counts();
    bus.key_right = 1'b1;
    repeat (3) step();
    bus.key_right = 1'b0;
    repeat (12) step();
    check("t3_glitch_right", n_right, 0);
    bus.key_right = 1'b1;
    repeat (10) step();
    bus.key_right = 1'b0;
    repeat (10) step();
    check("t3_clean_right", n_right, 2);

    // T4: put and down together; down pressed during a put sequence
    clear_counts();
    bus.key_put  = 1'b1;
    bus.key_down = 1'b1;
    repeat (20) step();
    bus.key_put  = 1'b0;
    bus.key_down = 1'b0;
    repeat (10) step();
    check("t4_same_cycle_down", n_down, 0);
    check("t4_same_cycle_put", n_put, 2);
    clear_counts();
    bus.key_put = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = bus.change_able_read;
    end
    check("t4_wait_car", int'(seen), 1);
    bus.key_down = 1'b1;
    repeat (8) step();
    bus.key_down = 1'b0;
    bus.key_put  = 1'b0;
    repeat (20) step();
    check("t4_dropped_down", n_down, 0);

    // T5a: game_over coincident with a right event
    clear_counts();
    bus.key_right = 1'b1;
    repeat (6) step();
    bus.game_over = 1'b1;
    repeat (10) step();
    bus.key_right = 1'b0;
    repeat (6) step();
    bus.key_put = 1'b1;
    repeat (10) step();
    bus.key_put = 1'b0;
    repeat (10) step();
    check("t5a_no_right", n_right, 0);
    check("t5a_no_put", n_put, 0);
    check("t5a_busy", int'(bus.busy), 0);

    // T5b: game_over during GAP lets the sequence finish, then freezes
    do_reset();
    repeat (5) step();
    bus.key_put = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = bus.put;
    end
    check("t5b_wait_put", int'(seen), 1);
    for (int i = 0; i < 10 && seen; i++) begin
      step();
      seen = bus.put;
    end
    check("t5b_gap_reached", int'(seen), 0);
    clear_counts();
    bus.game_over = 1'b1;
    bus.key_put   = 1'b0;
    repeat (15) step();
    check("t5b_turn", n_turn, 2);
    check("t5b_cs", n_cs, 2);
    bus.key_right = 1'b1;
    repeat (10) step();
    bus.key_right = 1'b0;
    repeat (10) step();
    check("t5b_frozen_right", n_right, 0);
    check("t5b_busy", int'(bus.busy), 0);

    // T6: reset in the middle of PUT
    do_reset();
    repeat (5) step();
    bus.key_put = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = bus.put;
    end
    check("t6_wait_put", int'(seen), 1);
    resetn = 1'b0;
    #1;
    check("t6_put_async", int'(bus.put), 0);
    check("t6_busy_async", int'(bus.busy), 0);
    bus.key_put = 1'b0;
    step();
    step();
    clear_counts();
    resetn = 1'b1;
    repeat (6) step();
    check("t6_home_cs", n_cs, 2);
    check("t6_home_first", first_cs, 1);

    // Randomized phase
    for (int it = 0; it < 400; it++) begin
      bus.key_put   = ($urandom_range(0, 3) == 0);
      bus.key_right = ($urandom_range(0, 3) == 0);
      bus.key_down  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) bus.game_over = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b0;
        step();
        bus.game_over = 1'b0;
        resetn = 1'b1;
      end
      repeat ($urandom_range(1, 10)) step();
    end

    bus.key_put   = 1'b0;
    bus.key_right = 1'b0;
    bus.key_down  = 1'b0;
    repeat (20) step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
